// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Walks every input vector of an N_IN-input gate, holds each for SETTLE
// cycles, then samples dut_y against exp_table and tallies mismatches.
// Optional build macro: GATE_SEQ_TRACE_EN prints a truth-table trace
// (header on start, one row per sampled vector). With the macro
// undefined nothing is printed and port behaviour is identical.
module gate_truth_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_table,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      fail_idx,
  output logic                 fail_valid
);

  // Counter only has to reach SETTLE-1; keep at least one bit.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [N_IN-1:0]  dut_in_nxt;
  logic [N_IN:0]    err_nxt;
  logic [N_IN-1:0]  fidx_nxt;
  logic             fv_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             pass_nxt;
  logic             mismatch;

  // Compare the gate output with the expected bit for the current vector.
  always_comb begin
    mismatch = (dut_y != exp_table[dut_in]);
  end

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dut_in_nxt = dut_in;
    err_nxt    = err_count;
    fidx_nxt   = fail_idx;
    fv_nxt     = fail_valid;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    pass_nxt   = pass;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_SETTLE;
          dut_in_nxt = {N_IN{1'b0}};
          err_nxt    = {(N_IN + 1){1'b0}};
          fv_nxt     = 1'b0;
          pass_nxt   = 1'b0;
          cnt_nxt    = {CW{1'b0}};
          busy_nxt   = 1'b1;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = S_SAMPLE;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_nxt = err_count + ERR_ONE;
          if (!fail_valid) begin
            fidx_nxt = dut_in;
            fv_nxt   = 1'b1;
          end else begin
            fidx_nxt = fail_idx;
          end
        end else begin
          err_nxt = err_count;
        end
        if (dut_in != VEC_LAST) begin
          dut_in_nxt = dut_in + VEC_ONE;
          cnt_nxt    = {CW{1'b0}};
          state_nxt  = S_SETTLE;
        end else begin
          // Final vector: dut_in holds, verdict includes this sample.
          state_nxt  = S_DONE;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
          pass_nxt   = (err_nxt == {(N_IN + 1){1'b0}});
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= {CW{1'b0}};
      dut_in     <= {N_IN{1'b0}};
      err_count  <= {(N_IN + 1){1'b0}};
      fail_idx   <= {N_IN{1'b0}};
      fail_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dut_in     <= dut_in_nxt;
      err_count  <= err_nxt;
      fail_idx   <= fidx_nxt;
      fail_valid <= fv_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
    end
  end

`ifdef GATE_SEQ_TRACE_EN
  // Print the truth-table header on start and one row per sampled vector.
  always_ff @(posedge clk) begin
    if (rst_n && (state == S_IDLE) && start) begin
      $display("in[%0d:0] | y", N_IN - 1);
    end else if (rst_n && (state == S_SAMPLE)) begin
      $display("%b | %b%s", dut_in, dut_y, mismatch ? " MISMATCH" : "");
    end
  end
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Self-checking bench for gate_truth_sequencer: a default 2-input instance
// and a 3-input / SETTLE=3 instance, checked against a truth-table model.
module tb_gate_truth_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  // 2-input, SETTLE=1 instance
  logic       start2;
  logic [3:0] exp2;
  logic       y2;
  logic [1:0] din2;
  logic       busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] fidx2;
  logic       and2;
  logic [3:0] g2;
  // 3-input, SETTLE=3 instance
  logic       start3;
  logic [7:0] exp3;
  logic       y3;
  logic [2:0] din3;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] fidx3;
  logic       and3;
  logic [7:0] g3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Gate under test: a true AND, or an arbitrary truth table.
  assign y2 = and2 ? (&din2) : g2[din2];
  assign y3 = and3 ? (&din3) : g3[din3];

  gate_truth_sequencer #(.N_IN(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2), .exp_table(exp2), .dut_y(y2),
    .dut_in(din2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_idx(fidx2), .fail_valid(fv2));

  gate_truth_sequencer #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .exp_table(exp3), .dut_y(y3),
    .dut_in(din3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_idx(fidx3), .fail_valid(fv3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: count vectors where the expected table and the gate's table differ.
  function automatic void model(input logic [15:0] e, input logic [15:0] g, input int n,
                                output int err, output int fidx);
    err  = 0;
    fidx = 0;
    for (int v = 0; v < (1 << n); v++) begin
      if (e[v] !== g[v]) begin
        if (err == 0) fidx = v;
        err++;
      end
    end
  endfunction

  task automatic run2(input logic [3:0] e, input logic use_and, input logic [3:0] g,
                      input bit pulse, input string tag);
    int total;
    int m_err, m_fidx, ev;
    logic [15:0] gt;
    total = 4 * (1 + 1);
    exp2  = e;
    and2  = use_and;
    g2    = g;
    gt    = use_and ? 16'h0008 : {12'h000, g};
    model({12'h000, e}, gt, 2, m_err, m_fidx);
    start2 = 1'b1;
    tick();
    chk({tag, ".acc_busy"}, 32'(busy2), 32'd1);
    chk({tag, ".acc_err"},  32'(err2),  32'd0);
    chk({tag, ".acc_fv"},   32'(fv2),   32'd0);
    chk({tag, ".acc_pass"}, 32'(pass2), 32'd0);
    chk({tag, ".acc_din"},  32'(din2),  32'd0);
    for (int k = 1; k <= total + 1; k++) begin
      start2 = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      ev = k / 2;
      if (ev > 3) ev = 3;
      chk({tag, ".done"}, 32'(done2), 32'(k == total));
      chk({tag, ".busy"}, 32'(busy2), 32'(k < total));
      if (k <= total) chk({tag, ".din"}, 32'(din2), 32'(ev));
    end
    start2 = 1'b0;
    chk({tag, ".pass"}, 32'(pass2), 32'(m_err == 0));
    chk({tag, ".err"},  32'(err2),  32'(m_err));
    chk({tag, ".fv"},   32'(fv2),   32'(m_err != 0));
    if (m_err != 0) chk({tag, ".fidx"}, 32'(fidx2), 32'(m_fidx));
    tick();
    chk({tag, ".hold_err"}, 32'(err2),  32'(m_err));
    chk({tag, ".hold_busy"}, 32'(busy2), 32'd0);
  endtask

  task automatic run3(input logic [7:0] e, input logic use_and, input logic [7:0] g,
                      input string tag);
    int total;
    int m_err, m_fidx, ev;
    logic [15:0] gt;
    total = 8 * (3 + 1);
    exp3  = e;
    and3  = use_and;
    g3    = g;
    gt    = use_and ? 16'h0080 : {8'h00, g};
    model({8'h00, e}, gt, 3, m_err, m_fidx);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk({tag, ".acc_busy"}, 32'(busy3), 32'd1);
    for (int k = 1; k <= total + 1; k++) begin
      tick();
      ev = k / 4;
      if (ev > 7) ev = 7;
      chk({tag, ".done"}, 32'(done3), 32'(k == total));
      if (k <= total) chk({tag, ".din"}, 32'(din3), 32'(ev));
    end
    chk({tag, ".pass"}, 32'(pass3), 32'(m_err == 0));
    chk({tag, ".err"},  32'(err3),  32'(m_err));
    chk({tag, ".fv"},   32'(fv3),   32'(m_err != 0));
    if (m_err != 0) chk({tag, ".fidx"}, 32'(fidx3), 32'(m_fidx));
  endtask

  initial begin
    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    exp2   = 4'b1000;
    exp3   = 8'h80;
    and2   = 1'b1;
    and3   = 1'b1;
    g2     = 4'h0;
    g3     = 8'h00;
    tick();
    tick();
    chk("rst.din",  32'(din2),  32'd0);
    chk("rst.busy", 32'(busy2), 32'd0);
    chk("rst.done", 32'(done2), 32'd0);
    chk("rst.pass", 32'(pass2), 32'd0);
    chk("rst.err",  32'(err2),  32'd0);
    chk("rst.fidx", 32'(fidx2), 32'd0);
    chk("rst.fv",   32'(fv2),   32'd0);
    chk("rst.busy3", 32'(busy3), 32'd0);
    rst_n = 1'b1;

    run2(4'b1000, 1'b1, 4'h0, 1'b0, "and2");
    run2(4'b1000, 1'b0, 4'h0, 1'b0, "stuck0");
    run2(4'b1000, 1'b0, 4'hF, 1'b0, "stuck1");
    run2(4'b1000, 1'b1, 4'h0, 1'b1, "pulse");
    for (int i = 0; i < 6; i++) begin
      run2(4'($urandom), 1'b0, 4'($urandom), 1'($urandom_range(0, 1)), "rand2");
    end

    // Abort during the third vector.
    and2   = 1'b0;
    g2     = 4'h0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort.din", 32'(din2), 32'd2);
    rst_n = 1'b0;
    tick();
    chk("abort.din",  32'(din2),  32'd0);
    chk("abort.busy", 32'(busy2), 32'd0);
    chk("abort.done", 32'(done2), 32'd0);
    chk("abort.err",  32'(err2),  32'd0);
    chk("abort.fidx", 32'(fidx2), 32'd0);
    chk("abort.fv",   32'(fv2),   32'd0);
    chk("abort.pass", 32'(pass2), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort.nodone", 32'(done2), 32'd0);
      chk("abort.idle",   32'(busy2), 32'd0);
    end
    run2(4'b1000, 1'b1, 4'h0, 1'b0, "after_abort");

    // Abort again, then start on the very first edge out of reset.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort2.busy", 32'(busy2), 32'd0);
    rst_n = 1'b1;
    run2(4'b0110, 1'b0, 4'b0110, 1'b0, "first_edge");

    run3(8'h80, 1'b1, 8'h00, "and3");
    run3(8'($urandom), 1'b0, 8'($urandom), "rand3a");
    run3(8'($urandom), 1'b0, 8'($urandom), "rand3b");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gate_truth_sequencer.md
GATE_TRUTH_SEQUENCER -- requirements
Module: gate_truth_sequencer

Interface
REQ-001 Parameter N_IN, default 2: number of inputs of the gate being exercised (1..4).
REQ-002 Parameter SETTLE, default 1: cycles each vector is held before dut_y is sampled (>=1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin one exhaustive truth-table pass; honoured only in IDLE.
REQ-006 exp_table  input  2**N_IN  expected output; bit i = expected y for input vector i; sampled per vector in SAMPLE.
REQ-007 dut_y  input  1  output of the gate under test.
REQ-008 dut_in  output  N_IN  input vector driven to the gate; bit 0 = LSB input.
REQ-009 busy  output  1  high from the start-accepting edge until DONE is entered.
REQ-010 done  output  1  one-cycle pulse when a pass completes.
REQ-011 pass  output  1  high when the last completed pass had zero mismatches.
REQ-012 err_count  output  N_IN+1  mismatches in the current/last pass.
REQ-013 fail_idx  output  N_IN  vector index of the first mismatch of the pass.
REQ-014 fail_valid  output  1  fail_idx holds a captured mismatch.

Function
REQ-015 FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE with start=1 at an edge: go to SETTLE; dut_in<=0; err_count<=0; fail_valid<=0; pass<=0; settle counter<=0; busy<=1.
REQ-017 SETTLE: counter increments each cycle; at count SETTLE-1 go to SAMPLE; dut_in stable throughout.
REQ-018 SAMPLE (one cycle): mismatch when dut_y != exp_table[dut_in]; on mismatch err_count increments; if fail_valid=0, fail_idx<=dut_in and fail_valid<=1.
REQ-019 SAMPLE, dut_in < 2**N_IN-1: dut_in<=dut_in+1, counter<=0, return to SETTLE.
REQ-020 SAMPLE, dut_in = 2**N_IN-1: go to DONE; dut_in holds its last value (no wrap).
REQ-021 DONE (one cycle): done=1, busy=0, pass = (err_count==0) including the final sample; next state IDLE.
REQ-022 done rises exactly 2**N_IN*(SETTLE+1) edges after the start-accepting edge (8 for defaults).
REQ-023 start while busy or in DONE is ignored; no restart, no queueing.
REQ-024 err_count cannot overflow (max 2**N_IN fits N_IN+1 bits); no saturation logic.
REQ-025 pass, err_count, fail_idx and fail_valid hold after DONE until the next accepted start.

Reset
REQ-026 rst_n=0 at an edge, in any state including mid-pass: state<=IDLE; dut_in, counter, err_count, fail_idx <= 0; busy, done, pass, fail_valid <= 0.
REQ-027 An aborted pass produces no done pulse; start on the first edge with rst_n=1 is accepted.

Configuration
REQ-028 Macro GATE_SEQ_TRACE_EN defined: each SAMPLE cycle prints one truth-table row, inputs MSB first, then " | ", dut_y, plus " MISMATCH" on error; a header row is printed on start.
REQ-029 Macro GATE_SEQ_TRACE_EN undefined: no output printed; RTL behaviour identical at every port.

Verification
REQ-030 Defaults, exp_table=4'b1000, dut_y=AND(dut_in) -> done 8 edges after start, pass=1, err_count=0, fail_valid=0; dut_in sequence 0,1,2,3, each held 2 cycles.
REQ-031 exp_table=4'b1000, dut_y stuck 0 -> err_count=1, fail_idx=3, fail_valid=1, pass=0.
REQ-032 exp_table=4'b1000, dut_y stuck 1 -> err_count=3, fail_idx=0, pass=0.
REQ-033 rst_n=0 during the third vector -> all outputs 0 next edge, no done; a new start then completes a full 8-edge pass.
REQ-034 start pulsed repeatedly while busy -> exactly one done pulse; timing unchanged.
REQ-035 SETTLE=3, N_IN=3, exp_table=8'h80, correct 3-input AND -> done 32 edges after start, pass=1; with GATE_SEQ_TRACE_EN, header plus 8 rows printed.
